i2c_req_arbiter: RTL and testbench

Round-robin arbiter sharing one I2C master transaction engine among NUM_REQ on-chip requesters. It latches the winning requester's command (7-bit address, r/w, write byte), launches it on the master, and waits for completion or timeout. It then returns read data and status to that requester only. It sits between the system-side clients and the I2C master that drives sclk/sda toward the bus slaves.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_req_arbiter_if.sv | 37 +++
 rtl/i2c_req_arbiter_rr_pick.sv | 34 +++
 rtl/i2c_req_arbiter.sv | 146 ++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C request arbiter: FSM states,
// completion status codes and bus field widths.
package i2c_pkg;

   localparam int unsigned AddrW = 7;
   localparam int unsigned DataW = 8;

   typedef enum logic [2:0] {
      StIdle,
      StArb,
      StLaunch,
      StWait,
      StFinish
   } state_e;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_NACK = 2'b01;
   localparam logic [1:0] ERR_TO   = 2'b10;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and master-side signals of the arbiter. The master modport is
// the arbiter's own view; the slave modport is the surrounding clients/engine.
interface i2c_req_arbiter_if
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
);

   logic [NUM_REQ-1:0]       req;
   logic [AddrW*NUM_REQ-1:0] req_addr;
   logic [NUM_REQ-1:0]       req_rw;
   logic [DataW*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       done;
   logic [DataW-1:0]         rdata;
   logic [1:0]               err;

   logic                     m_start;
   logic [AddrW-1:0]         m_addr;
   logic                     m_rw;
   logic [DataW-1:0]         m_wdata;
   logic                     m_busy;
   logic                     m_done;
   logic                     m_nack;
   logic [DataW-1:0]         m_rdata;

   modport master (
      input  req, req_addr, req_rw, req_wdata, m_busy, m_done, m_nack, m_rdata,
      output gnt, done, rdata, err, m_start, m_addr, m_rw, m_wdata
   );

   modport slave (
      output req, req_addr, req_rw, req_wdata, m_busy, m_done, m_nack, m_rdata,
      input  gnt, done, rdata, err, m_start, m_addr, m_rw, m_wdata
   );

endinterface

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after the
// pointer, wrapping modulo N. Returns one-hot, binary index and a valid flag.
module rr_pick #(
   parameter int unsigned N    = 4,
   parameter int unsigned IdxW = 2
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o
);

   localparam int unsigned SumW = IdxW + 1;

   logic [SumW-1:0] pos;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      pos     = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr_i} + SumW'(k);
         if (pos >= SumW'(N)) pos = pos - SumW'(N);
         if (!valid_o && req_i[pos[IdxW-1:0]]) begin
            valid_o                  = 1'b1;
            idx_o                    = pos[IdxW-1:0];
            gnt_o[pos[IdxW-1:0]]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master engine among NUM_REQ requesters:
// latch the winner's command, launch it, wait for completion or timeout, report back.
module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter int unsigned TO_W        = 16
) (
   input logic               clk,
   input logic               rst,
   i2c_req_arbiter_if.master bus
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     ptr_q, ptr_d, idx_q, idx_d;
   logic [TO_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
   logic [DataW-1:0]    rdata_q, rdata_d, m_wdata_q, m_wdata_d;
   logic [1:0]          err_q, err_d;
   logic                m_start_q, m_start_d, m_rw_q, m_rw_d;
   logic [AddrW-1:0]    m_addr_q, m_addr_d;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IdxW-1:0]     pick_idx;
   logic                pick_valid;
   logic                timeout;

   rr_pick #(
      .N    (NUM_REQ),
      .IdxW (IdxW)
   ) u_pick (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign timeout = (cnt_q == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (|bus.req && !bus.m_busy) state_d = StArb;
         StArb:    state_d = pick_valid ? StLaunch : StIdle;
         StLaunch: state_d = StWait;
         StWait:   if (bus.m_done || timeout) state_d = StFinish;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs; done reuses gnt_q as its one-hot target.
   always_comb begin
      gnt_d     = gnt_q;
      done_d    = '0;
      m_start_d = 1'b0;
      m_addr_d  = m_addr_q;
      m_rw_d    = m_rw_q;
      m_wdata_d = m_wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      case (state_q)
         StArb: begin
            gnt_d = pick_gnt;
            idx_d = pick_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (pick_gnt[i]) begin
                  m_addr_d  = bus.req_addr[i*AddrW +: AddrW];
                  m_rw_d    = bus.req_rw[i];
                  m_wdata_d = bus.req_wdata[i*DataW +: DataW];
               end
            end
         end
         StLaunch: begin
            m_start_d = 1'b1;
            cnt_d     = '0;
         end
         StWait: begin
            cnt_d = cnt_q + TO_W'(1);
            if (bus.m_done) begin
               done_d = gnt_q;
               err_d  = bus.m_nack ? ERR_NACK : ERR_OK;
               if (m_rw_q) rdata_d = bus.m_rdata;
            end else if (timeout) begin
               done_d = gnt_q;
               err_d  = ERR_TO;
            end
         end
         StFinish: begin
            gnt_d = '0;
            ptr_d = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + IdxW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q     <= '0;
         done_q    <= '0;
         m_start_q <= 1'b0;
         m_addr_q  <= '0;
         m_rw_q    <= 1'b0;
         m_wdata_q <= '0;
         rdata_q   <= '0;
         err_q     <= ERR_OK;
         cnt_q     <= '0;
         ptr_q     <= '0;
         idx_q     <= '0;
      end else begin
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         m_start_q <= m_start_d;
         m_addr_q  <= m_addr_d;
         m_rw_q    <= m_rw_d;
         m_wdata_q <= m_wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.done    = done_q;
   assign bus.rdata   = rdata_q;
   assign bus.err     = err_q;
   assign bus.m_start = m_start_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_rw    = m_rw_q;
   assign bus.m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: stimulus pushes expected launches/completions,
// a monitor checks them as m_start and done appear, a master model answers launches.
module tb_i2c_req_arbiter;

   localparam int unsigned NR = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   i2c_req_arbiter_if #(.NUM_REQ(NR)) bus ();

   i2c_req_arbiter #(
      .NUM_REQ     (NR),
      .TIMEOUT_CYC (100),
      .TO_W        (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0] onehot;
      logic [6:0] addr;
      logic       rw;
      logic [7:0] wdata;
      logic [1:0] err;
      logic [7:0] rdata;
      int         lat;
   } exp_t;

   typedef struct {
      bit         respond;
      int         delay;
      logic       nack;
      logic [7:0] rdata;
   } mcfg_t;

   exp_t  exp_q[$];
   mcfg_t mst_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    start_cyc = 0;
   logic  prev_start = 1'b0;
   exp_t  mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic set_cmd(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
      bus.req_addr[7*i +: 7]  = a;
      bus.req_rw[i]           = rw;
      bus.req_wdata[8*i +: 8] = wd;
   endtask

   task automatic exp_push(input logic [3:0] oh, input logic [6:0] a, input logic rw,
                           input logic [7:0] wd, input logic [1:0] e, input logic [7:0] rd,
                           input int lat);
      exp_t x;
      x.onehot = oh; x.addr = a; x.rw = rw; x.wdata = wd;
      x.err = e; x.rdata = rd; x.lat = lat;
      exp_q.push_back(x);
   endtask

   task automatic mst_push(input bit resp, input int d, input logic nk, input logic [7:0] rd);
      mcfg_t c;
      c.respond = resp; c.delay = d; c.nack = nk; c.rdata = rd;
      mst_q.push_back(c);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(|bus.done) && n < budget);
      if (!(|bus.done)) begin
         checks++;
         errors++;
         $display("FAIL done_wait: no done pulse within %0d cycles", budget);
      end
   endtask

   task automatic wait_start(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.m_start && n < budget);
      if (!bus.m_start) begin
         checks++;
         errors++;
         $display("FAIL start_wait: no m_start within %0d cycles", budget);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: launch fields checked against the head entry, popped on done.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.m_start) begin
            chk("start_one_cycle", 32'(prev_start), 32'h0);
            if (exp_q.size() == 0) begin
               chk("start_unexpected", 32'(bus.m_start), 32'h0);
            end else begin
               mon_e = exp_q[0];
               chk("launch_gnt", 32'(bus.gnt), 32'(mon_e.onehot));
               chk("launch_addr", 32'(bus.m_addr), 32'(mon_e.addr));
               chk("launch_rw", 32'(bus.m_rw), 32'(mon_e.rw));
               chk("launch_wdata", 32'(bus.m_wdata), 32'(mon_e.wdata));
               start_cyc = cyc;
            end
         end
         if (|bus.done) begin
            if (exp_q.size() == 0) begin
               chk("done_unexpected", 32'(bus.done), 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("done_vec", 32'(bus.done), 32'(mon_e.onehot));
               chk("done_gnt", 32'(bus.gnt), 32'(mon_e.onehot));
               chk("done_err", 32'(bus.err), 32'(mon_e.err));
               chk("done_rdata", 32'(bus.rdata), 32'(mon_e.rdata));
               if (mon_e.lat > 0) chk("done_latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
            end
         end
      end
      prev_start = bus.m_start;
   end

   // Master engine model: answers each m_start after a configured delay, or never.
   initial begin
      mcfg_t c;
      bus.m_done  = 1'b0;
      bus.m_nack  = 1'b0;
      bus.m_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (rst && bus.m_start && mst_q.size() > 0) begin
            c = mst_q.pop_front();
            if (c.respond) begin
               repeat (c.delay) @(posedge clk);
               #1;
               bus.m_done  = 1'b1;
               bus.m_nack  = c.nack;
               bus.m_rdata = c.rdata;
               @(posedge clk);
               #1;
               bus.m_done  = 1'b0;
               bus.m_nack  = 1'b0;
            end
         end
      end
   end

   initial begin
      bus.req       = '0;
      bus.req_addr  = '0;
      bus.req_rw    = '0;
      bus.req_wdata = '0;
      bus.m_busy    = 1'b0;
      rst           = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_start", 32'(bus.m_start), 32'h0);
      chk("rst_addr", 32'(bus.m_addr), 32'h0);
      chk("rst_rw", 32'(bus.m_rw), 32'h0);
      chk("rst_wdata", 32'(bus.m_wdata), 32'h0);
      chk("rst_rdata", 32'(bus.rdata), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // Round-robin with all four requesting: order 0,1,2,3,0
      for (int i = 0; i < 4; i++) set_cmd(i, 7'(8'h10 + i), 1'b0, 8'(8'hC0 + i));
      for (int k = 0; k < 5; k++) begin
         exp_push(4'(1 << (k % 4)), 7'(8'h10 + (k % 4)), 1'b0, 8'(8'hC0 + (k % 4)),
                  2'b00, 8'h00, 11);
         mst_push(1'b1, 10, 1'b0, 8'h00);
      end
      bus.req = 4'b1111;
      repeat (5) wait_done(300);
      bus.req = 4'b0000;

      // Single write, held off while the master reports busy
      set_cmd(0, 7'h50, 1'b0, 8'hA5);
      exp_push(4'b0001, 7'h50, 1'b0, 8'hA5, 2'b00, 8'h00, 31);
      mst_push(1'b1, 30, 1'b0, 8'hFF);
      bus.m_busy = 1'b1;
      bus.req    = 4'b0001;
      repeat (5) @(negedge clk);
      chk("busy_hold_gnt", 32'(bus.gnt), 32'h0);
      bus.m_busy = 1'b0;
      wait_done(300);
      bus.req = 4'b0000;

      // Read return
      set_cmd(2, 7'h3C, 1'b1, 8'h00);
      exp_push(4'b0100, 7'h3C, 1'b1, 8'h00, 2'b00, 8'h7E, 6);
      mst_push(1'b1, 5, 1'b0, 8'h7E);
      bus.req = 4'b0100;
      wait_done(300);
      bus.req = 4'b0000;

      // NACK on a write keeps old rdata, then the next arbitration proceeds
      set_cmd(3, 7'h22, 1'b0, 8'h11);
      exp_push(4'b1000, 7'h22, 1'b0, 8'h11, 2'b01, 8'h7E, 8);
      mst_push(1'b1, 7, 1'b1, 8'h99);
      bus.req = 4'b1000;
      wait_done(300);
      bus.req = 4'b0000;
      set_cmd(1, 7'h45, 1'b1, 8'h00);
      exp_push(4'b0010, 7'h45, 1'b1, 8'h00, 2'b00, 8'h5A, 4);
      mst_push(1'b1, 3, 1'b0, 8'h5A);
      bus.req = 4'b0010;
      wait_done(300);
      bus.req = 4'b0000;

      // Timeout: no m_done, done exactly 100 cycles after m_start
      set_cmd(0, 7'h68, 1'b1, 8'h00);
      exp_push(4'b0001, 7'h68, 1'b1, 8'h00, 2'b10, 8'h5A, 100);
      mst_push(1'b0, 0, 1'b0, 8'h00);
      bus.req = 4'b0001;
      wait_done(300);
      bus.req = 4'b0000;

      // m_done in the same cycle the limit is reached wins
      set_cmd(2, 7'h0F, 1'b1, 8'h00);
      exp_push(4'b0100, 7'h0F, 1'b1, 8'h00, 2'b00, 8'hE1, 100);
      mst_push(1'b1, 99, 1'b0, 8'hE1);
      bus.req = 4'b0100;
      wait_done(300);
      bus.req = 4'b0000;

      // Reset in the middle of WAIT
      set_cmd(2, 7'h2A, 1'b0, 8'h77);
      exp_push(4'b0100, 7'h2A, 1'b0, 8'h77, 2'b00, 8'h00, -1);
      mst_push(1'b0, 0, 1'b0, 8'h00);
      bus.req = 4'b0100;
      wait_start(50);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_gnt", 32'(bus.gnt), 32'h0);
      chk("midrst_start", 32'(bus.m_start), 32'h0);
      chk("midrst_addr", 32'(bus.m_addr), 32'h0);
      exp_q.delete();
      mst_q.delete();
      bus.req = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Pointer back at 0: 1010 grants 1 first, then 3
      set_cmd(1, 7'h19, 1'b1, 8'h00);
      set_cmd(3, 7'h7B, 1'b0, 8'hD2);
      exp_push(4'b0010, 7'h19, 1'b1, 8'h00, 2'b00, 8'h33, 5);
      mst_push(1'b1, 4, 1'b0, 8'h33);
      exp_push(4'b1000, 7'h7B, 1'b0, 8'hD2, 2'b00, 8'h33, 3);
      mst_push(1'b1, 2, 1'b0, 8'h00);
      bus.req = 4'b1010;
      wait_done(300);
      bus.req = 4'b1000;
      wait_done(300);
      bus.req = 4'b0000;

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      chk("idle_gnt", 32'(bus.gnt), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
